ende_seq_ctrl: RTL
==================

// Module: ende_seq_ctrl
// PURPOSE
//  Avalon-MM slave sequencer for the encode/decode (EnDe) datapath enable. Replaces the bare
//  write-a-bit enable: software writes START, block waits for datapath ready, holds the enable
//  for one job, tracks completion with a watchdog, and reports status/IRQ to the Nios II CPU.
// PARAMETERS
//  TO_W       32    width of timeout counter/register (bits)
//  TO_DEFAULT 4096  reset value of TIMEOUT register (cycles); 0 = watchdog disabled
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   asynchronous, active-low reset
//  address    in   2   Avalon register select
//  chipselect in   1   Avalon select
//  write_n    in   1   Avalon write strobe, active-low
//  writedata  in   32  Avalon write data
//  readdata   out  32  Avalon read data, zero read latency (combinational on address)
//  dp_ready   in   1   datapath idle, can accept a job
//  dp_done    in   1   datapath job-complete pulse/level (sampled only in RUN)
//  en_out     out  1   datapath enable, high for whole job
//  mode_out   out  1   job mode: 0 encode, 1 decode (stable while en_out high)
//  irq        out  1   level interrupt = irq_en & (done | timeout)
// BEHAVIOUR
//  Registers (write = chipselect & ~write_n; unused bits read 0):
//   0 CTRL    W: b0 START, b1 MODE, b2 ABORT (START/ABORT self-clearing). R: b1 = mode reg
//   1 STATUS  R: b0 busy, b1 done, b2 timeout, b3 aborted. W: 1 to clear b1..b3 (W1C)
//   2 TIMEOUT R/W TO_W bits; value loaded into watchdog on entry to RUN
//   3 IRQEN   R/W b0
//  Reset: state IDLE, en_out=0, mode_out=0, irq=0, STATUS=0, IRQEN=0, TIMEOUT=TO_DEFAULT.
//  FSM:
//   IDLE : START write -> latch MODE into mode_out, clear done/timeout/aborted -> ARM
//   ARM  : dp_ready=1 -> RUN next cycle (en_out rises on RUN entry); ABORT -> IDLE, aborted=1
//   RUN  : en_out=1, watchdog counts down from TIMEOUT
//          dp_done=1 -> DONE; watchdog hits 0 (TIMEOUT!=0) -> DONE with timeout=1
//          ABORT -> DONE with aborted=1
//   DONE : en_out=0 for exactly one cycle (cooldown), set done (unless timeout/abort) -> IDLE
//  busy = (state != IDLE). Latency: START write at cycle N with dp_ready=1 -> en_out high at
//   N+2 (ARM at N+1, RUN at N+2). dp_done at cycle M -> en_out low at M+1.
//  Watchdog: TIMEOUT=T gives en_out high for exactly T cycles if no dp_done. T=0: never times out.
//  Boundaries:
//   START while busy: ignored, no status change. MODE write while busy: ignored.
//   START+ABORT same write: ABORT wins in ARM/RUN; in IDLE START is accepted, ABORT ignored.
//   dp_done and watchdog expiry same cycle: done wins (done=1, timeout=0).
//   dp_done and ABORT same cycle: done wins.
//   W1C clear and hardware set same cycle: set wins.
//   TIMEOUT write during RUN: affects next job only.
//   dp_done outside RUN: ignored. dp_ready dropping in RUN: no effect.
//   Async reset mid-job: en_out drops immediately, all state to reset values.
//  Flags done/timeout/aborted mutually exclusive per job; sticky until W1C or next START.
// TESTING
//  1 Reset: assert reset_n=0 mid-RUN -> en_out=0 same cycle; reads: STATUS=0, TIMEOUT=4096.
//  2 Normal: TIMEOUT=100, CTRL=0x3 with dp_ready=1 -> en_out at +2, mode_out=1; dp_done after 10
//    cycles -> en_out low next cycle, STATUS=0x2; IRQEN=1 -> irq=1; write STATUS=0x2 -> irq=0.
//  3 Timeout: TIMEOUT=5, START, never dp_done -> en_out high exactly 5 cycles, STATUS=0x4.
//  4 ARM wait+abort: dp_ready=0, START -> STATUS=0x1, en_out=0; CTRL=0x4 -> STATUS=0x8.
//  5 Collisions: dp_done on watchdog-expiry cycle -> STATUS=0x2; START while busy -> no restart,
//    mode_out unchanged; W1C on done-set cycle -> done stays 1.
//  6 TIMEOUT=0: START, hold 10000 cycles without dp_done -> still busy; ABORT -> STATUS=0x8.

Source files
------------

// File: rtl/ende_seq_ctrl.sv
// Avalon-MM sequencer for the EnDe datapath enable: START/ABORT control,
// ready handshake, per-job watchdog and sticky status with level IRQ.
module ende_seq_ctrl #(
  parameter int TO_W       = 32,
  parameter int TO_DEFAULT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        dp_ready,
  input  logic        dp_done,
  output logic        en_out,
  output logic        mode_out,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic            mode_reg;
  logic [TO_W-1:0] timeout_reg;
  logic [TO_W-1:0] wd_reg;
  logic            irq_en_reg;
  logic            done_reg, timeout_flag_reg, aborted_reg;
  logic            busy;
  logic [31:0]     to_rd;

  logic wr_en, ctrl_wr, start_wr, abort_wr, status_wr, wd_expire;

  assign wr_en     = chipselect & ~write_n;
  assign ctrl_wr   = wr_en && (address == 2'd0);
  assign status_wr = wr_en && (address == 2'd1);
  assign start_wr  = ctrl_wr & writedata[0];
  assign abort_wr  = ctrl_wr & writedata[2];
  // A loaded value of 0 never reaches 1, so the watchdog stays disabled.
  assign wd_expire = (wd_reg == TO_W'(1));

  generate
    if (TO_W < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:TO_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start_wr) state_next = S_ARM;
      S_ARM: begin
        if (abort_wr)      state_next = S_IDLE;
        else if (dp_ready) state_next = S_RUN;
      end
      S_RUN:  if (dp_done || wd_expire || abort_wr) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    en_out = (state_reg == S_RUN);
    busy   = (state_reg != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg    <= 1'b0;
      timeout_reg <= TO_W'(TO_DEFAULT);
      irq_en_reg  <= 1'b0;
      wd_reg      <= '0;
    end else begin
      if (ctrl_wr && state_reg == S_IDLE) mode_reg <= writedata[1];
      if (wr_en && address == 2'd2) timeout_reg <= writedata[TO_W-1:0];
      if (wr_en && address == 2'd3) irq_en_reg <= writedata[0];
      if (state_reg == S_ARM && state_next == S_RUN)
        wd_reg <= timeout_reg;
      else if (state_reg == S_RUN && wd_reg != '0)
        wd_reg <= wd_reg - TO_W'(1);
    end
  end

  // Hardware sets are written after the W1C clears so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_reg         <= 1'b0;
      timeout_flag_reg <= 1'b0;
      aborted_reg      <= 1'b0;
    end else if (state_reg == S_IDLE && start_wr) begin
      done_reg         <= 1'b0;
      timeout_flag_reg <= 1'b0;
      aborted_reg      <= 1'b0;
    end else begin
      if (status_wr && writedata[1]) done_reg         <= 1'b0;
      if (status_wr && writedata[2]) timeout_flag_reg <= 1'b0;
      if (status_wr && writedata[3]) aborted_reg      <= 1'b0;
      if (state_reg == S_RUN) begin
        if (dp_done)        done_reg         <= 1'b1;
        else if (wd_expire) timeout_flag_reg <= 1'b1;
        else if (abort_wr)  aborted_reg      <= 1'b1;
      end
      if (state_reg == S_ARM && abort_wr) aborted_reg <= 1'b1;
    end
  end

  always_comb begin
    to_rd = '0;
    to_rd[TO_W-1:0] = timeout_reg;
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1]   = mode_reg;
      2'd1: readdata[3:0] = {aborted_reg, timeout_flag_reg, done_reg, busy};
      2'd2: readdata      = to_rd;
      2'd3: readdata[0]   = irq_en_reg;
      default: readdata   = '0;
    endcase
  end

  assign mode_out = mode_reg;
  assign irq      = irq_en_reg & (done_reg | timeout_flag_reg);

endmodule
